mano_seq_timer: RTL and testbench



---
 rtl/mano_seq_timer.sv | 148 ++++++++++++++
 tb/tb_mano_seq_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mano_seq_timer.sv
// mano_seq_timer: sequence counter and instruction-decode stage of the basic
// computer. Produces one-hot timing T0..T5, the registered opcode decode D0..D7
// and the latched indirect bit I.
// Optional feature macro: MANO_SEQ_INT_EN hosts the interrupt-cycle flip-flop R.
// Without it, R is held at 0 and ien/fgi/fgo/int_clr are ignored.
module mano_seq_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        sc_clr,
    input  logic [15:0] ir,
    input  logic        ien,
    input  logic        fgi,
    input  logic        fgo,
    input  logic        int_clr,
    output logic [5:0]  T,
    output logic [7:0]  D,
    output logic        I,
    output logic        R,
    output logic        seq_err
);

    localparam logic [2:0] SC_T0 = 3'd0;
    localparam logic [2:0] SC_T2 = 3'd2;
    localparam logic [2:0] SC_T5 = 3'd5;

    logic [2:0] r_sc;
    logic [2:0] w_sc_nxt;
    logic       w_overrun;
    logic       w_decode_en;
    logic [7:0] r_d;
    logic       r_i;
    logic       r_int;
    logic       r_seq_err;
    logic       w_unused;

    // One-hot decode of the 3-bit opcode field.
    function automatic logic [7:0] opcode_onehot(input logic [2:0] op);
        logic [7:0] v;
        v = 8'h00;
        v[op] = 1'b1;
        return v;
    endfunction

    // Sequence counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc <= SC_T0;
        end else begin
            r_sc <= w_sc_nxt;
        end
    end

    // Next step: halt > clear > overrun wrap > increment. Any value past T5
    // is treated as an overrun so the counter always recovers to T0.
    always_comb begin
        w_sc_nxt  = r_sc;
        w_overrun = 1'b0;
        if (!run) begin
            w_sc_nxt = r_sc;
        end else if (sc_clr) begin
            w_sc_nxt = SC_T0;
        end else if (r_sc >= SC_T5) begin
            w_sc_nxt  = SC_T0;
            w_overrun = 1'b1;
        end else begin
            w_sc_nxt = r_sc + 3'd1;
        end
    end

    // Timing outputs: one-hot of the current step.
    always_comb begin
        case (r_sc)
            3'd0:    T = 6'b000001;
            3'd1:    T = 6'b000010;
            3'd2:    T = 6'b000100;
            3'd3:    T = 6'b001000;
            3'd4:    T = 6'b010000;
            3'd5:    T = 6'b100000;
            default: T = 6'b000001;
        endcase
    end

    // Decode happens only on a live edge leaving T2 that is neither cleared
    // nor inside an interrupt cycle.
    always_comb begin
        w_decode_en = run & ~sc_clr & ~r_int & (r_sc == SC_T2);
    end

    // Opcode decode and indirect-bit latch; held at all other times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= 8'h00;
            r_i <= 1'b0;
        end else if (w_decode_en) begin
            r_d <= opcode_onehot(ir[14:12]);
            r_i <= ir[15];
        end else begin
            r_d <= r_d;
            r_i <= r_i;
        end
    end

    // Overrun flag: high for the single T0 cycle that follows a T5 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= w_overrun;
        end
    end

`ifdef MANO_SEQ_INT_EN
    // Interrupt-cycle flip-flop: set from T3 onward on a pending flag, clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int <= 1'b0;
        end else if (!run) begin
            r_int <= r_int;
        end else if (int_clr) begin
            r_int <= 1'b0;
        end else if (ien && (fgi || fgo) && (r_sc > SC_T2)) begin
            r_int <= 1'b1;
        end else begin
            r_int <= r_int;
        end
    end

    assign w_unused = ^ir[11:0];
`else
    // Interrupt cycle not hosted here: flag stays cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int <= 1'b0;
        end else begin
            r_int <= 1'b0;
        end
    end

    assign w_unused = ^{ien, fgi, fgo, int_clr, ir[11:0]};
`endif

    assign D       = r_d;
    assign I       = r_i;
    assign R       = r_int;
    assign seq_err = r_seq_err;

endmodule

// File: tb/tb_mano_seq_timer.sv
// Self-checking bench for mano_seq_timer: directed scenarios plus randomized
// traffic, all compared against a step-number behavioural model.
module tb_mano_seq_timer;

    logic        clk = 1'b0;
    logic        rst, run, sc_clr, ien, fgi, fgo, int_clr;
    logic [15:0] ir;
    logic [5:0]  T;
    logic [7:0]  D;
    logic        I, R, seq_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: plain step number and latched fields.
    int         m_step;
    logic [7:0] m_d;
    logic       m_i, m_r, m_err;

    mano_seq_timer dut (
        .clk(clk), .rst(rst), .run(run), .sc_clr(sc_clr), .ir(ir),
        .ien(ien), .fgi(fgi), .fgo(fgo), .int_clr(int_clr),
        .T(T), .D(D), .I(I), .R(R), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_vec();
        logic [5:0] t;
        t = 6'b000001 << m_step;
        return {t, m_d, m_i, m_r, m_err};
    endfunction

    // Apply inputs for one cycle, advance the model, clock, settle.
    task automatic cyc(input logic rst_v, input logic run_v, input logic clr_v,
                       input logic [15:0] ir_v, input logic ien_v, input logic fgi_v,
                       input logic fgo_v, input logic ic_v);
        logic [7:0] oh;
        rst = rst_v; run = run_v; sc_clr = clr_v; ir = ir_v;
        ien = ien_v; fgi = fgi_v; fgo = fgo_v; int_clr = ic_v;
        if (rst_v) begin
            m_step = 0; m_d = 8'h00; m_i = 1'b0; m_r = 1'b0; m_err = 1'b0;
        end else if (!run_v) begin
            m_err = 1'b0;
        end else begin
            if (m_step == 2 && !clr_v && !m_r) begin
                oh = 8'h00;
                oh[ir_v[14:12]] = 1'b1;
                m_d = oh;
                m_i = ir_v[15];
            end
`ifdef MANO_SEQ_INT_EN
            if (ic_v) m_r = 1'b0;
            else if (ien_v && (fgi_v || fgo_v) && m_step >= 3) m_r = 1'b1;
`endif
            if (clr_v) begin
                m_step = 0; m_err = 1'b0;
            end else if (m_step == 5) begin
                m_step = 0; m_err = 1'b1;
            end else begin
                m_step = m_step + 1; m_err = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({T, D, I, R, seq_err} !== {6'b000001, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: got T=%b D=%b I=%b R=%b err=%b, want T=000001 D=0 I=0 R=0 err=0",
                     T, D, I, R, seq_err);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] want_t;
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            want_t = 6'b000001 << (k % 6);
            n_cmp++;
            if (T !== want_t || seq_err !== (k == 6)) begin
                n_bad++;
                $display("FAIL sequence step %0d: got T=%b err=%b, want T=%b err=%b",
                         k, T, seq_err, want_t, (k == 6));
            end
        end
    endtask

    task automatic test_fetch_decode();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'hB123, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b001000 || D !== 8'b00001000 || I !== 1'b1) begin
            n_bad++;
            $display("FAIL decode T3: got T=%b D=%b I=%b, want T=001000 D=00001000 I=1", T, D, I);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b000001 || D !== 8'b00001000 || I !== 1'b1) begin
            n_bad++;
            $display("FAIL decode hold after clr: got T=%b D=%b I=%b, want T=000001 D=00001000 I=1", T, D, I);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({T, D, I, R, seq_err} !== exp_vec() || D !== 8'b00001000) begin
                n_bad++;
                $display("FAIL decode hold T%0d: got %b, want %b", k + 1, {T, D, I, R, seq_err}, exp_vec());
            end
        end
    endtask

    task automatic test_halt();
        // From T2: leave to T3 latching B123 again.
        cyc(1'b0, 1'b1, 1'b0, 16'hB123, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b001000 || seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL halt with clr: got T=%b err=%b, want T=001000 err=0", T, seq_err);
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b001000 || D !== 8'b00001000) begin
            n_bad++;
            $display("FAIL halt hold: got T=%b D=%b, want T=001000 D=00001000", T, D);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b010000) begin
            n_bad++;
            $display("FAIL halt resume: got T=%b, want T=010000", T);
        end
    endtask

    task automatic test_clear_t2();
        cyc(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (T !== 6'b000001 || D !== 8'b00001000 || I !== 1'b1 || seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL clear at T2: got T=%b D=%b I=%b err=%b, want T=000001 D=00001000 I=1 err=0",
                     T, D, I, seq_err);
        end
    endtask

    task automatic test_interrupt();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'hB123, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef MANO_SEQ_INT_EN
        n_cmp++;
        if (R !== 1'b1) begin
            n_bad++;
            $display("FAIL interrupt set: got R=%b, want R=1", R);
        end
`else
        n_cmp++;
        if (R !== 1'b0) begin
            n_bad++;
            $display("FAIL interrupt disabled: got R=%b, want R=0", R);
        end
`endif
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
`ifdef MANO_SEQ_INT_EN
        if (T !== 6'b001000 || D !== 8'b00001000 || I !== 1'b1) begin
            n_bad++;
            $display("FAIL interrupt suppress decode: got T=%b D=%b I=%b, want T=001000 D=00001000 I=1", T, D, I);
        end
`else
        if (T !== 6'b001000 || D !== 8'b10000000 || I !== 1'b0) begin
            n_bad++;
            $display("FAIL decode without interrupt: got T=%b D=%b I=%b, want T=001000 D=10000000 I=0", T, D, I);
        end
`endif
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (R !== 1'b0 || {T, D, I, R, seq_err} !== exp_vec()) begin
            n_bad++;
            $display("FAIL interrupt clear: got %b, want %b (R=0)", {T, D, I, R, seq_err}, exp_vec());
        end
    endtask

    task automatic test_random();
        logic r_v, run_v, clr_v, ie_v, fi_v, fo_v, ic_v;
        for (int k = 0; k < 600; k++) begin
            r_v   = ($urandom_range(0, 99) < 2);
            run_v = ($urandom_range(0, 99) < 85);
            clr_v = ($urandom_range(0, 99) < 12);
            ie_v  = ($urandom_range(0, 99) < 30);
            fi_v  = ($urandom_range(0, 99) < 30);
            fo_v  = ($urandom_range(0, 99) < 20);
            ic_v  = ($urandom_range(0, 99) < 10);
            cyc(r_v, run_v, clr_v, 16'($urandom), ie_v, fi_v, fo_v, ic_v);
            n_cmp++;
            if ({T, D, I, R, seq_err} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cycle %0d: got {T,D,I,R,err}=%b, want %b",
                         k, {T, D, I, R, seq_err}, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sc_clr = 1'b0; ir = 16'h0000;
        ien = 1'b0; fgi = 1'b0; fgo = 1'b0; int_clr = 1'b0;
        m_step = 0; m_d = 8'h00; m_i = 1'b0; m_r = 1'b0; m_err = 1'b0;
        test_reset();
        test_sequence();
        test_fetch_decode();
        test_halt();
        test_clear_t2();
        test_interrupt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
